// File: rtl/msg_pkg.sv
// Shared types and helpers for the message stream arbiter.
//   arb_state_t : arbiter FSM states
//   pick_t      : round-robin search result (found flag + index)
//   rr_pick     : round-robin search over up to NUM_SRC_MAX requesters
package msg_pkg;

   localparam int unsigned NUM_SRC_MAX = 4;
   localparam int unsigned SRC_ID_W    = $clog2(NUM_SRC_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                found;
      logic [SRC_ID_W-1:0] idx;
   } pick_t;

   // First set bit of req searching upward from last+1, wrapping modulo n.
   function automatic pick_t rr_pick(input logic [NUM_SRC_MAX-1:0] req,
                                     input logic [SRC_ID_W-1:0]    last,
                                     input int unsigned            n);
      pick_t       p;
      int unsigned idx;
      p = '0;
      for (int unsigned i = 1; i <= NUM_SRC_MAX; i++) begin
         if (i <= n && !p.found) begin
            idx = (32'(last) + i) % n;
            if (req[idx[SRC_ID_W-1:0]]) begin
               p.found = 1'b1;
               p.idx   = idx[SRC_ID_W-1:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/msg_stream_arbiter_rr_picker.sv
// Combinational round-robin priority search.
//   req     : per-source request
//   last    : index granted most recently (search starts one above it)
//   idx_c   : chosen index
//   found_c : at least one request present
module rr_picker
   import msg_pkg::*;
#(
   parameter int unsigned NUM_SRC = 2
) (
   input  logic [NUM_SRC-1:0]         req,
   input  logic [$clog2(NUM_SRC)-1:0] last,
   output logic [$clog2(NUM_SRC)-1:0] idx_c,
   output logic                       found_c
);

   localparam int unsigned ID_W = $clog2(NUM_SRC);

   pick_t pick;

   always_comb begin
      pick    = rr_pick(NUM_SRC_MAX'(req), SRC_ID_W'(last), NUM_SRC);
      idx_c   = ID_W'(pick.idx);
      found_c = pick.found;
   end

endmodule

// File: rtl/msg_stream_arbiter.sv
// Packet-locked round-robin arbiter feeding the message parser's single
// AXI-Stream input from NUM_SRC sources. Packets longer than MAX_BEATS are
// cut short with tlast+tuser and the remainder is drained upstream.
//   clk, rst        : clock, async active-high reset
//   s_t*            : per-source streams (source k in slice k)
//   m_t*            : stream to parser (combinational from granted source)
//   m_src_id        : granted source index, valid with m_tvalid
//   trunc_pulse     : one-cycle pulse after a truncating beat
module msg_stream_arbiter
   import msg_pkg::*;
#(
   parameter int unsigned NUM_SRC     = 2,
   parameter int unsigned DATA_BYTES  = 8,
   parameter int unsigned TKEEP_WIDTH = 8,
   parameter int unsigned MAX_BEATS   = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SRC-1:0]              s_tvalid,
   output logic [NUM_SRC-1:0]              s_tready,
   input  logic [NUM_SRC-1:0]              s_tlast,
   input  logic [NUM_SRC-1:0]              s_tuser,
   input  logic [NUM_SRC*TKEEP_WIDTH-1:0]  s_tkeep,
   input  logic [NUM_SRC*8*DATA_BYTES-1:0] s_tdata,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   output logic                            m_tlast,
   output logic                            m_tuser,
   output logic [TKEEP_WIDTH-1:0]          m_tkeep,
   output logic [8*DATA_BYTES-1:0]         m_tdata,
   output logic [$clog2(NUM_SRC)-1:0]      m_src_id,
   output logic                            trunc_pulse
);

   localparam int unsigned ID_W  = $clog2(NUM_SRC);
   localparam int unsigned DW    = 8 * DATA_BYTES;
   localparam int unsigned CNT_W = $clog2(MAX_BEATS);

   arb_state_t       state, state_n;
   logic [ID_W-1:0]  grant, grant_n;
   logic [ID_W-1:0]  last_grant, last_grant_n;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
   logic             trunc_n;

   logic [ID_W-1:0]  pick_idx;
   logic             pick_found;
   logic             at_max;
   logic             force_end;
   logic             hs;

   rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
      .req     (s_tvalid),
      .last    (last_grant),
      .idx_c   (pick_idx),
      .found_c (pick_found)
   );

   // State and bookkeeping registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         last_grant  <= ID_W'(NUM_SRC - 1);
         beat_cnt    <= '0;
         trunc_pulse <= 1'b0;
      end else begin
         state       <= state_n;
         grant       <= grant_n;
         last_grant  <= last_grant_n;
         beat_cnt    <= beat_cnt_n;
         trunc_pulse <= trunc_n;
      end
   end

   // Next-state, handshake steering and data mux.
   always_comb begin
      state_n      = state;
      grant_n      = grant;
      last_grant_n = last_grant;
      beat_cnt_n   = beat_cnt;
      trunc_n      = 1'b0;
      s_tready     = '0;
      m_tvalid     = 1'b0;
      m_tlast      = 1'b0;
      m_tuser      = 1'b0;
      m_tkeep      = '0;
      m_tdata      = '0;
      m_src_id     = '0;
      at_max       = (beat_cnt == CNT_W'(MAX_BEATS - 1));
      force_end    = 1'b0;
      hs           = 1'b0;

      unique case (state)
         IDLE: begin
            if (pick_found) begin
               grant_n    = pick_idx;
               beat_cnt_n = '0;
               state_n    = PASS;
            end
         end

         PASS: begin
            // A real tlast on the final allowed beat is a legal full packet.
            force_end        = at_max && !s_tlast[grant];
            m_tvalid         = s_tvalid[grant];
            s_tready[grant]  = m_tready;
            m_tdata          = s_tdata[DW*32'(grant) +: DW];
            m_tkeep          = s_tkeep[TKEEP_WIDTH*32'(grant) +: TKEEP_WIDTH];
            m_tlast          = s_tlast[grant] | force_end;
            m_tuser          = s_tuser[grant] | force_end;
            m_src_id         = grant;
            hs               = s_tvalid[grant] && m_tready;
            if (hs) begin
               beat_cnt_n = beat_cnt + CNT_W'(1);
               if (s_tlast[grant]) begin
                  last_grant_n = grant;
                  state_n      = IDLE;
               end else if (at_max) begin
                  trunc_n = 1'b1;
                  state_n = DRAIN;
               end
            end
         end

         DRAIN: begin
            // Swallow the rest of the oversized packet; parser sees nothing.
            s_tready[grant] = 1'b1;
            if (s_tvalid[grant] && s_tlast[grant]) begin
               last_grant_n = grant;
               state_n      = IDLE;
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Directed bench for msg_stream_arbiter (2 sources, 8-byte beats, 4 beats max).
module tb_msg_stream_arbiter;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic        user;
   } beat_t;

   typedef struct {
      logic [1:0]  src;
      logic [63:0] data;
      logic        last;
      logic        user;
   } obeat_t;

   logic        clk;
   logic        rst;
   logic [1:0]  s_tvalid;
   logic [1:0]  s_tready;
   logic [1:0]  s_tlast;
   logic [1:0]  s_tuser;
   logic [15:0] s_tkeep;
   logic [127:0] s_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        m_tuser;
   logic [7:0]  m_tkeep;
   logic [63:0] m_tdata;
   logic [0:0]  m_src_id;
   logic        trunc_pulse;

   beat_t  srcq[2][$];
   obeat_t outq[$];
   logic   rdyq[$];
   int     vectors;
   int     errors;
   int     trunc_cnt;
   int     drain_cnt;

   msg_stream_arbiter #(
      .NUM_SRC(2), .DATA_BYTES(8), .TKEEP_WIDTH(8), .MAX_BEATS(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .s_tlast    (s_tlast),
      .s_tuser    (s_tuser),
      .s_tkeep    (s_tkeep),
      .s_tdata    (s_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .m_tuser    (m_tuser),
      .m_tkeep    (m_tkeep),
      .m_tdata    (m_tdata),
      .m_src_id   (m_src_id),
      .trunc_pulse(trunc_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present the head of each source queue.
   task automatic drive();
      for (int k = 0; k < 2; k++) begin
         if (srcq[k].size() > 0) begin
            s_tvalid[k]         = 1'b1;
            s_tlast[k]          = srcq[k][0].last;
            s_tuser[k]          = srcq[k][0].user;
            s_tdata[k*64 +: 64] = srcq[k][0].data;
            s_tkeep[k*8 +: 8]   = srcq[k][0].last ? 8'h0F : 8'hFF;
         end else begin
            s_tvalid[k]         = 1'b0;
            s_tlast[k]          = 1'b0;
            s_tuser[k]          = 1'b0;
            s_tdata[k*64 +: 64] = '0;
            s_tkeep[k*8 +: 8]   = '0;
         end
      end
   endtask

   task automatic load(input int k, input logic [7:0] first, input logic [7:0] step,
                       input int n, input logic usr);
      logic [7:0] b;
      beat_t      bt;
      for (int i = 0; i < n; i++) begin
         b       = first + 8'(i) * step;
         bt.data = {8{b}};
         bt.last = (i == n - 1);
         bt.user = usr;
         srcq[k].push_back(bt);
      end
      drive();
      #1;
   endtask

   // One clock: record transfers at the negedge, then advance sources.
   task automatic tick();
      logic   hs[2];
      obeat_t ob;
      @(negedge clk);
      if (m_tvalid && m_tready) begin
         ob.src  = 2'(m_src_id);
         ob.data = m_tdata;
         ob.last = m_tlast;
         ob.user = m_tuser;
         outq.push_back(ob);
      end
      for (int k = 0; k < 2; k++) begin
         hs[k] = s_tvalid[k] && s_tready[k];
         if (hs[k] && !m_tvalid) drain_cnt++;
      end
      if (trunc_pulse) trunc_cnt++;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
         if (hs[k]) void'(srcq[k].pop_front());
      m_tready = (rdyq.size() > 0) ? rdyq.pop_front() : 1'b1;
      drive();
      #1;
   endtask

   task automatic run_until_out(input string tag, input int n, input int budget);
      int c;
      c = 0;
      while (outq.size() < n && c < budget) begin
         tick();
         c++;
      end
      check(tag, 64'(outq.size()), 64'(n));
   endtask

   task automatic expect_beat(input string tag, input int i, input logic [1:0] src,
                              input logic [7:0] b, input logic last, input logic user);
      if (i < outq.size()) begin
         check({tag, "_src"},  64'(outq[i].src),  64'(src));
         check({tag, "_data"}, outq[i].data,      {8{b}});
         check({tag, "_last"}, 64'(outq[i].last), 64'(last));
         check({tag, "_user"}, 64'(outq[i].user), 64'(user));
      end else begin
         check({tag, "_missing"}, 64'(outq.size()), 64'(i + 1));
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      m_tready = 1'b1;
      srcq[0].delete();
      srcq[1].delete();
      rdyq.delete();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      outq.delete();
      trunc_cnt = 0;
      drain_cnt = 0;
   endtask

   initial begin
      int c;
      vectors   = 0;
      errors    = 0;
      trunc_cnt = 0;
      drain_cnt = 0;
      rst       = 1'b1;
      m_tready  = 1'b1;
      s_tvalid  = '0;
      s_tlast   = '0;
      s_tuser   = '0;
      s_tkeep   = '0;
      s_tdata   = '0;

      // Reset state
      #2;
      check("rst_s_tready",   64'(s_tready),    64'd0);
      check("rst_m_tvalid",   64'(m_tvalid),    64'd0);
      check("rst_m_tlast",    64'(m_tlast),     64'd0);
      check("rst_m_tuser",    64'(m_tuser),     64'd0);
      check("rst_m_src_id",   64'(m_src_id),    64'd0);
      check("rst_trunc",      64'(trunc_pulse), 64'd0);
      do_reset();

      // Single 3-beat packet from source 0
      load(0, 8'h11, 8'h11, 3, 1'b0);
      check("t1_idle_lat", 64'(m_tvalid), 64'd0);
      tick();
      check("t1_b1_valid", 64'(m_tvalid), 64'd1);
      check("t1_b1_data",  m_tdata, {8{8'h11}});
      check("t1_b1_keep",  64'(m_tkeep), 64'hFF);
      check("t1_b1_rdy",   64'(s_tready), 64'b01);
      check("t1_b1_last",  64'(m_tlast), 64'd0);
      tick();
      tick();
      check("t1_b3_last",  64'(m_tlast), 64'd1);
      check("t1_b3_keep",  64'(m_tkeep), 64'h0F);
      tick();
      check("t1_bubble_valid", 64'(m_tvalid), 64'd0);
      check("t1_bubble_rdy",   64'(s_tready), 64'd0);
      check("t1_bubble_data",  m_tdata, 64'd0);
      check("t1_count", 64'(outq.size()), 64'd3);
      expect_beat("t1_o0", 0, 2'd0, 8'h11, 1'b0, 1'b0);
      expect_beat("t1_o1", 1, 2'd0, 8'h22, 1'b0, 1'b0);
      expect_beat("t1_o2", 2, 2'd0, 8'h33, 1'b1, 1'b0);

      // Rotation between two busy sources; source 1 second packet carries tuser
      do_reset();
      load(0, 8'hA0, 8'h01, 2, 1'b0);
      load(0, 8'hA2, 8'h01, 2, 1'b0);
      load(1, 8'hB0, 8'h01, 2, 1'b0);
      load(1, 8'hB2, 8'h01, 2, 1'b1);
      run_until_out("t2_count", 8, 60);
      expect_beat("t2_o0", 0, 2'd0, 8'hA0, 1'b0, 1'b0);
      expect_beat("t2_o1", 1, 2'd0, 8'hA1, 1'b1, 1'b0);
      expect_beat("t2_o2", 2, 2'd1, 8'hB0, 1'b0, 1'b0);
      expect_beat("t2_o3", 3, 2'd1, 8'hB1, 1'b1, 1'b0);
      expect_beat("t2_o4", 4, 2'd0, 8'hA2, 1'b0, 1'b0);
      expect_beat("t2_o5", 5, 2'd0, 8'hA3, 1'b1, 1'b0);
      expect_beat("t2_o6", 6, 2'd1, 8'hB2, 1'b0, 1'b1);
      expect_beat("t2_o7", 7, 2'd1, 8'hB3, 1'b1, 1'b1);

      // Oversized 6-beat packet from source 1 is truncated at beat 4
      outq.delete();
      trunc_cnt = 0;
      drain_cnt = 0;
      load(1, 8'hC1, 8'h01, 6, 1'b0);
      c = 0;
      while (srcq[1].size() > 0 && c < 40) begin
         tick();
         c++;
      end
      check("t3_drained", 64'(srcq[1].size()), 64'd0);
      tick();
      check("t3_count", 64'(outq.size()), 64'd4);
      expect_beat("t3_o0", 0, 2'd1, 8'hC1, 1'b0, 1'b0);
      expect_beat("t3_o2", 2, 2'd1, 8'hC3, 1'b0, 1'b0);
      expect_beat("t3_o3", 3, 2'd1, 8'hC4, 1'b1, 1'b1);
      check("t3_trunc_cnt", 64'(trunc_cnt), 64'd1);
      check("t3_drain_cnt", 64'(drain_cnt), 64'd2);

      // Exactly MAX_BEATS with a real tlast is not truncated
      outq.delete();
      trunc_cnt = 0;
      drain_cnt = 0;
      load(0, 8'hD1, 8'h01, 4, 1'b0);
      run_until_out("t4_count", 4, 30);
      repeat (2) tick();
      check("t4_count_after", 64'(outq.size()), 64'd4);
      expect_beat("t4_o3", 3, 2'd0, 8'hD4, 1'b1, 1'b0);
      check("t4_trunc_cnt", 64'(trunc_cnt), 64'd0);
      check("t4_drain_cnt", 64'(drain_cnt), 64'd0);

      // Downstream backpressure 1,0,0,1 while source 1 waits
      do_reset();
      load(0, 8'hE1, 8'h01, 3, 1'b0);
      tick();
      load(1, 8'hF1, 8'h01, 1, 1'b0);
      m_tready = 1'b1;
      rdyq.push_back(1'b0);
      rdyq.push_back(1'b0);
      rdyq.push_back(1'b1);
      #1;
      for (int i = 0; i < 4; i++) begin
         check("t5_rdy_mirror", 64'(s_tready), 64'({1'b0, m_tready}));
         tick();
      end
      run_until_out("t5_count", 4, 30);
      expect_beat("t5_o0", 0, 2'd0, 8'hE1, 1'b0, 1'b0);
      expect_beat("t5_o1", 1, 2'd0, 8'hE2, 1'b0, 1'b0);
      expect_beat("t5_o2", 2, 2'd0, 8'hE3, 1'b1, 1'b0);
      expect_beat("t5_o3", 3, 2'd1, 8'hF1, 1'b1, 1'b0);

      // Asynchronous reset on beat 2, then source 0 wins first again
      do_reset();
      load(0, 8'h71, 8'h01, 3, 1'b0);
      tick();
      tick();
      check("t6_beat2_data", m_tdata, {8{8'h72}});
      rst = 1'b1;
      #1;
      check("t6_rst_valid",  64'(m_tvalid),    64'd0);
      check("t6_rst_rdy",    64'(s_tready),    64'd0);
      check("t6_rst_last",   64'(m_tlast),     64'd0);
      check("t6_rst_src",    64'(m_src_id),    64'd0);
      check("t6_rst_trunc",  64'(trunc_pulse), 64'd0);
      srcq[0].delete();
      srcq[1].delete();
      load(0, 8'h81, 8'h01, 1, 1'b0);
      load(1, 8'h91, 8'h01, 1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      outq.delete();
      run_until_out("t6_count", 2, 20);
      expect_beat("t6_o0", 0, 2'd0, 8'h81, 1'b1, 1'b0);
      expect_beat("t6_o1", 1, 2'd1, 8'h91, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
